mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the instruction-fetch requester (IF) and the data-memory stage requester (DM) of the RV32I pipeline.
- Sequences one outstanding transaction at a time, routes each response back to its owner, and generates the fetch and memory stall signals consumed by the hazard logic.
- Handles fetch flushes on taken branch/JAL/JALR while a fetch is in flight, and bounds fetch starvation and response timeouts.

---
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters,
// one transaction in flight, with flush dropping, starvation bound and response timeout.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_wr,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [3:0]      dm_byte,
    output logic            dm_valid,
    output logic [XLEN-1:0] dm_rdata,
    output logic            mem_req,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_byte,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            err
);
    typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} state_t;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t        state;
    logic          drop;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          idle, if_force, dm_win, if_win, xfer, tmo;
    assign idle      = state == IDLE;
    assign if_force  = if_req && starve_cnt == SW'(STARVE_MAX);
    assign dm_win    = idle && dm_req && !if_force;
    assign if_win    = idle && if_req && !dm_win;
    assign mem_req   = !rst && (dm_win || if_win);
    assign mem_wr    = dm_win && dm_wr;
    assign mem_addr  = dm_win ? dm_addr : if_addr;
    assign mem_wdata = dm_win ? dm_wdata : '0;
    assign mem_byte  = dm_win ? dm_byte : 4'b1111;
    assign xfer      = mem_req && mem_gnt;
    // last silent WAIT cycle before the abort
    assign tmo       = !idle && !mem_rvalid && tmo_cnt == TW'(TIMEOUT - 1);
    assign if_valid  = !rst && state == WAIT_IF && mem_rvalid && !drop && !if_flush;
    assign dm_valid  = !rst && state == WAIT_DM && mem_rvalid;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign stall_if  = !rst && if_req && !if_valid;
    assign stall_mem = !rst && dm_req && !dm_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            drop       <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            err <= tmo;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    drop    <= 1'b0;
                    if (xfer)
                        state <= dm_win ? WAIT_DM : WAIT_IF;
                    if ((xfer && if_win) || !if_req)
                        starve_cnt <= '0;
                    else if (xfer && dm_win && starve_cnt != SW'(STARVE_MAX))
                        starve_cnt <= starve_cnt + 1'b1;
                end
                default: begin
                    if (mem_rvalid || tmo) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (state == WAIT_IF && if_flush)
                            drop <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, response scoreboard popped by a monitor on
// if_valid/dm_valid, plus a latency-programmable memory model.
module tb_mem_port_arbiter;
    logic        clk = 0, rst;
    logic        if_req, if_flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_wr, dm_valid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_byte, mem_byte;
    logic        mem_req, mem_wr, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem, err;

    typedef struct packed {logic dm; logic [31:0] data;} exp_t;
    exp_t        exp_q[$];
    int          vectors = 0, miscompares = 0;
    int          lat = 1;
    bit          resp_en = 1;
    logic [31:0] mem [logic [31:0]];

    mem_port_arbiter #(.XLEN(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_byte(dm_byte), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte(mem_byte), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // memory model: captures a transfer at negedge, answers lat cycles later
    initial begin
        logic [31:0] a, wd, t;
        logic        w;
        logic [3:0]  be;
        mem_rvalid = 0;
        mem_rdata  = 0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req && mem_gnt && resp_en) begin
                a = mem_addr; w = mem_wr; wd = mem_wdata; be = mem_byte;
                if (w) begin
                    t = mem[a];
                    for (int b = 0; b < 4; b++)
                        if (be[b]) t[8*b +: 8] = wd[8*b +: 8];
                    mem[a] = t;
                end
                repeat (lat) @(posedge clk);
                #1;
                mem_rvalid = 1;
                mem_rdata  = w ? 32'h0 : mem[a];
                @(posedge clk);
                #1;
                mem_rvalid = 0;
                mem_rdata  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (if_valid || dm_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got if_valid=%0b dm_valid=%0b, expected no response", if_valid, dm_valid);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (if_valid && dm_valid) begin
                    miscompares++;
                    $display("FAIL sb_both_valid: got both valids, expected one");
                end else if (e.dm != dm_valid || e.data !== (dm_valid ? dm_rdata : if_rdata)) begin
                    miscompares++;
                    $display("FAIL sb_response: got dm=%0b data=%h, expected dm=%0b data=%h",
                             dm_valid, dm_valid ? dm_rdata : if_rdata, e.dm, e.data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit dm, input int max, output int n);
        n = 0;
        while (!(dm ? dm_valid : if_valid) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!(dm ? dm_valid : if_valid)) chk(dm ? "wait_dm_valid" : "wait_if_valid", 0, 1);
    endtask

    initial begin
        int n;
        mem[32'h100]  = 32'h00500093;
        mem[32'h104]  = 32'h00400093;
        mem[32'h108]  = 32'h00000013;
        mem[32'h10C]  = 32'h00100113;
        mem[32'h200]  = 32'h0000006F;
        mem[32'h2000] = 32'h12345678;
        mem[32'h3000] = 32'h11111111;
        rst = 1; if_req = 1; if_addr = 32'h100; if_flush = 0;
        dm_req = 1; dm_wr = 0; dm_addr = 32'h2000; dm_wdata = 0; dm_byte = 4'hF;
        mem_gnt = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_stall_if", stall_if, 0);
        chk("rst_stall_mem", stall_mem, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 0; if_req = 0; dm_req = 0;
        tick();

        // single fetch, 3-cycle memory
        lat = 3;
        if_req = 1; if_addr = 32'h100;
        exp_q.push_back('{1'b0, 32'h00500093});
        @(negedge clk);
        chk("f_mem_req", mem_req, 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_wr", mem_wr, 0);
        chk("f_mem_byte", mem_byte, 4'hF);
        chk("f_mem_wdata", mem_wdata, 0);
        chk("f_stall_if", stall_if, 1);
        wait_valid(0, 10, n);
        chk("f_latency", n, 3);
        chk("f_stall_if_rel", stall_if, 0);
        tick();
        if_req = 0;
        tick();

        // contention: DM first, IF two cycles later
        lat = 1;
        if_req = 1; if_addr = 32'h108;
        dm_req = 1; dm_wr = 0; dm_addr = 32'h2000; dm_byte = 4'b0011;
        exp_q.push_back('{1'b1, 32'h12345678});
        exp_q.push_back('{1'b0, 32'h00000013});
        @(negedge clk);
        chk("c_dm_addr", mem_addr, 32'h2000);
        chk("c_dm_byte", mem_byte, 4'b0011);
        @(negedge clk);
        chk("c_dm_valid", dm_valid, 1);
        chk("c_stall_mem", stall_mem, 0);
        chk("c_stall_if", stall_if, 1);
        tick();
        dm_req = 0;
        @(negedge clk);
        chk("c_if_req", mem_req, 1);
        chk("c_if_addr", mem_addr, 32'h108);
        @(negedge clk);
        chk("c_if_valid", if_valid, 1);
        chk("c_stall_if_rel", stall_if, 0);
        tick();
        if_req = 0;
        tick();

        // starvation: 4 DM wins then forced IF win
        if_req = 1; if_addr = 32'h10C;
        dm_req = 1; dm_addr = 32'h2000; dm_byte = 4'hF;
        repeat (4) exp_q.push_back('{1'b1, 32'h12345678});
        exp_q.push_back('{1'b0, 32'h00100113});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("s_arb%0d", k), mem_addr, k < 4 ? 32'h2000 : 32'h10C);
            @(negedge clk);
        end
        chk("s_if_valid", if_valid, 1);
        chk("s_starve_clr", 32'(dut.starve_cnt), 0);
        tick();
        if_req = 0; dm_req = 0;
        tick();

        // flush while fetch in flight
        lat = 2;
        if_req = 1; if_addr = 32'h104;
        @(negedge clk);
        chk("fl_addr", mem_addr, 32'h104);
        tick();
        if_flush = 1; if_req = 0;
        @(negedge clk);
        tick();
        if_flush = 0;
        @(negedge clk);
        chk("fl_rvalid_seen", mem_rvalid, 1);
        chk("fl_no_valid", if_valid, 0);
        tick();
        lat = 1;
        if_req = 1; if_addr = 32'h200;
        exp_q.push_back('{1'b0, 32'h0000006F});
        @(negedge clk);
        chk("fl_new_addr", mem_addr, 32'h200);
        wait_valid(0, 10, n);
        chk("fl_new_lat", n, 1);
        tick();
        if_req = 0;
        tick();

        // back-pressure then timeout
        mem_gnt = 0; resp_en = 0;
        dm_req = 1; dm_wr = 0; dm_addr = 32'h2000; dm_byte = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_req%0d", k), mem_req, 1);
            chk($sformatf("bp_addr%0d", k), mem_addr, 32'h2000);
            tick();
        end
        mem_gnt = 1;
        @(negedge clk);
        tick();
        mem_gnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("to_err_low%0d", k), err, 0);
            chk($sformatf("to_wait%0d", k), mem_req, 0);
        end
        @(negedge clk);
        chk("to_err", err, 1);
        chk("to_rearb", mem_req, 1);
        @(negedge clk);
        chk("to_err_pulse", err, 0);
        tick();
        dm_req = 0; resp_en = 1; mem_gnt = 1;
        tick();

        // store with byte enables, then load back
        dm_req = 1; dm_wr = 1; dm_addr = 32'h3000; dm_wdata = 32'hDEADBEEF; dm_byte = 4'b0011;
        exp_q.push_back('{1'b1, 32'h0});
        @(negedge clk);
        chk("st_wr", mem_wr, 1);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_byte", mem_byte, 4'b0011);
        wait_valid(1, 10, n);
        tick();
        dm_req = 0;
        tick();
        dm_req = 1; dm_wr = 0; dm_byte = 4'hF;
        exp_q.push_back('{1'b1, 32'h1111BEEF});
        @(negedge clk);
        wait_valid(1, 10, n);
        tick();
        dm_req = 0;
        tick();

        // reset mid WAIT_DM
        lat = 3;
        dm_req = 1; dm_addr = 32'h2000;
        @(negedge clk);
        chk("r_issue", mem_req, 1);
        tick();
        rst = 1; dm_req = 0; mem_gnt = 0;
        @(negedge clk);
        chk("r_mem_req", mem_req, 0);
        chk("r_dm_valid", dm_valid, 0);
        tick();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("r_no_valid%0d", k), dm_valid, 0);
        end
        chk("r_state_idle", 32'(dut.state), 0);
        tick(); tick();
        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
